// File: rtl/cdu_timing_pkg.sv
// Shared types and constants for the CDU four-phase timing receive path.
// Contents: FSM state enum, phase index type, error codes, one-hot helper.
package cdu_timing_pkg;

    localparam int unsigned NUM_PHASES = 4;
    localparam int unsigned PHASE_W    = 2;
    localparam int unsigned ERR_W      = 2;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        CONFIRM = 2'd1,
        LOCKED  = 2'd2,
        SLIP    = 2'd3
    } fsm_state_t;

    typedef logic [PHASE_W-1:0] phase_idx_t;
    typedef logic [ERR_W-1:0]   err_code_t;

    localparam err_code_t ERR_NONE  = 2'd0;
    localparam err_code_t ERR_ORDER = 2'd1;
    localparam err_code_t ERR_MULTI = 2'd2;
    localparam err_code_t ERR_GAP   = 2'd3;

    // Index of the set bit of a one-hot phase vector (0 when none set).
    function automatic phase_idx_t onehot_to_idx(input logic [NUM_PHASES-1:0] oh);
        phase_idx_t idx;
        idx = '0;
        for (int i = 0; i < NUM_PHASES; i++) begin
            if (oh[i]) idx = PHASE_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/cdu_sync.sv
// Multi-flop synchronizer for one asynchronous FAZ strobe.
// Ports: clk, rst_n (async active-low, clears chain), d (async in), q (synchronized out).
module cdu_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_q;

    // Shift chain; the last stage is the synchronized value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
        end
    end

    assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/faz_phase_monitor.sv
// Receive side of the CDU four-phase timing interface: synchronizes FAZ1HI..FAZ4HI,
// checks 1-2-3-4 order, locks, recovers the phase index and an 800 Hz strobe,
// and reports order / multi-edge / dropout faults.
// Ports: clk, rst_n, FAZ1HI..FAZ4HI (async), locked, phase, phase_valid,
//        p800_stb, err_stb, err_code.
// Optional macro FAZ_ERR_COUNT_EN adds err_clr (in) and err_count[7:0] (out).
module faz_phase_monitor
    import cdu_timing_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned LOCK_CYCLES = 4,
    parameter int unsigned MAX_GAP     = 64,
    parameter int unsigned DIV_RATIO   = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       FAZ1HI,
    input  logic       FAZ2HI,
    input  logic       FAZ3HI,
    input  logic       FAZ4HI,
`ifdef FAZ_ERR_COUNT_EN
    input  logic       err_clr,
    output logic [7:0] err_count,
`endif
    output logic       locked,
    output logic [1:0] phase,
    output logic       phase_valid,
    output logic       p800_stb,
    output logic       err_stb,
    output logic [1:0] err_code
);

    localparam int unsigned GAP_W  = $clog2(MAX_GAP + 1);
    localparam int unsigned DIV_W  = (DIV_RATIO > 2) ? $clog2(DIV_RATIO) : 1;
    localparam int unsigned GOOD_W = 4;

    localparam logic [GAP_W-1:0]  GAP_MAX   = GAP_W'(MAX_GAP);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(MAX_GAP - 1);
    localparam logic [GOOD_W-1:0] GOOD_LOCK = GOOD_W'(LOCK_CYCLES);

    logic [NUM_PHASES-1:0] faz_raw, faz_s, faz_d, rise;
    logic                  any_rise, multi, single, exp_hit, gap_expire;
    phase_idx_t            rise_idx, exp_phase;

    fsm_state_t            state, state_n;
    phase_idx_t            phase_n;
    logic                  phase_valid_n, p800_n, err_stb_n, locked_n;
    err_code_t             err_code_n;
    logic [GAP_W-1:0]      gap_cnt, gap_n;
    logic [GOOD_W-1:0]     good_cnt, good_n, good_inc;
    logic [DIV_W-1:0]      div_cnt, div_n, div_inc;

    assign faz_raw = {FAZ4HI, FAZ3HI, FAZ2HI, FAZ1HI};

    // One synchronizer per phase strobe.
    for (genvar i = 0; i < NUM_PHASES; i++) begin : g_sync
        cdu_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
            .clk   (clk),
            .rst_n (rst_n),
            .d     (faz_raw[i]),
            .q     (faz_s[i])
        );
    end

    // Delayed copy for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) faz_d <= '0;
        else        faz_d <= faz_s;
    end

    assign rise       = faz_s & ~faz_d;
    assign any_rise   = |rise;
    // More than one bit set: clearing the lowest set bit leaves something.
    assign multi      = (rise & (rise - NUM_PHASES'(1))) != '0;
    assign single     = any_rise & ~multi;
    assign rise_idx   = onehot_to_idx(rise);
    assign exp_phase  = phase + PHASE_W'(1);
    assign exp_hit    = single && (rise_idx == exp_phase);
    // An edge in the expiry cycle wins, so expiry requires a quiet cycle.
    assign gap_expire = !any_rise && (gap_cnt == GAP_LAST);
    assign good_inc   = good_cnt + GOOD_W'(1);
    assign div_inc    = div_cnt + DIV_W'(1);

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= HUNT;
            phase       <= '0;
            phase_valid <= 1'b0;
            p800_stb    <= 1'b0;
            err_stb     <= 1'b0;
            err_code    <= ERR_NONE;
            locked      <= 1'b0;
            gap_cnt     <= '0;
            good_cnt    <= '0;
            div_cnt     <= '0;
        end else begin
            state       <= state_n;
            phase       <= phase_n;
            phase_valid <= phase_valid_n;
            p800_stb    <= p800_n;
            err_stb     <= err_stb_n;
            err_code    <= err_code_n;
            locked      <= locked_n;
            gap_cnt     <= gap_n;
            good_cnt    <= good_n;
            div_cnt     <= div_n;
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_n       = state;
        phase_n       = phase;
        phase_valid_n = 1'b0;
        p800_n        = 1'b0;
        err_stb_n     = 1'b0;
        err_code_n    = err_code;
        good_n        = good_cnt;
        div_n         = div_cnt;
        if (any_rise)                gap_n = '0;
        else if (gap_cnt == GAP_MAX) gap_n = gap_cnt;
        else                         gap_n = gap_cnt + GAP_W'(1);

        unique case (state)
            HUNT: begin
                if (single) begin
                    phase_n       = rise_idx;
                    phase_valid_n = 1'b1;
                    good_n        = '0;
                    state_n       = CONFIRM;
                end
            end
            CONFIRM: begin
                if (multi || gap_expire) begin
                    good_n  = '0;
                    state_n = HUNT;
                end else if (single) begin
                    phase_n       = rise_idx;
                    phase_valid_n = 1'b1;
                    if (!exp_hit) begin
                        good_n = '0;
                    end else if (rise_idx == PHASE_W'(NUM_PHASES - 1)) begin
                        good_n = good_inc;
                        if (good_inc == GOOD_LOCK) begin
                            div_n   = '0;
                            state_n = LOCKED;
                        end
                    end
                end
            end
            LOCKED: begin
                if (multi) begin
                    err_stb_n  = 1'b1;
                    err_code_n = ERR_MULTI;
                    state_n    = SLIP;
                end else if (single && !exp_hit) begin
                    err_stb_n  = 1'b1;
                    err_code_n = ERR_ORDER;
                    state_n    = SLIP;
                end else if (exp_hit) begin
                    phase_n       = rise_idx;
                    phase_valid_n = 1'b1;
                    if (rise_idx == '0) begin
                        div_n  = div_inc;
                        p800_n = (div_inc == '0);
                    end
                end else if (gap_expire) begin
                    err_stb_n  = 1'b1;
                    err_code_n = ERR_GAP;
                    state_n    = SLIP;
                end
            end
            SLIP: begin
                good_n  = '0;
                div_n   = '0;
                state_n = HUNT;
            end
            default: state_n = HUNT;
        endcase

        locked_n = (state_n == LOCKED);
    end

`ifdef FAZ_ERR_COUNT_EN
    // Saturating fault counter; a clear coinciding with a fault leaves one count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= '0;
        end else if (err_clr) begin
            err_count <= err_stb ? 8'd1 : 8'd0;
        end else if (err_stb && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_faz_phase_monitor.sv
// Directed self-checking bench for faz_phase_monitor (default parameters).
module tb_faz_phase_monitor;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] faz = 4'b0000;
    logic       locked, phase_valid, p800_stb, err_stb;
    logic [1:0] phase, err_code;
`ifdef FAZ_ERR_COUNT_EN
    logic       err_clr = 1'b0;
    logic [7:0] err_count;
`endif

    int nvec = 0;
    int nmis = 0;

    faz_phase_monitor dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .FAZ1HI      (faz[0]),
        .FAZ2HI      (faz[1]),
        .FAZ3HI      (faz[2]),
        .FAZ4HI      (faz[3]),
`ifdef FAZ_ERR_COUNT_EN
        .err_clr     (err_clr),
        .err_count   (err_count),
`endif
        .locked      (locked),
        .phase       (phase),
        .phase_valid (phase_valid),
        .p800_stb    (p800_stb),
        .err_stb     (err_stb),
        .err_code    (err_code)
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt++;

    // Event recorder, sampled on the falling edge.
    int   pv_cnt = 0, p800_cnt = 0, err_cnt = 0;
    int   last_pv_edge = 0, last_p800_edge = 0, last_err_edge = 0, lock_edge = 0;
    int   last_phase = 0;
    logic last_err_locked = 1'b0;
    logic locked_q = 1'b0;
    always @(negedge clk) begin
        if (phase_valid) begin pv_cnt++; last_pv_edge = edge_cnt; last_phase = int'(phase); end
        if (p800_stb)    begin p800_cnt++; last_p800_edge = edge_cnt; end
        if (err_stb)     begin err_cnt++; last_err_edge = edge_cnt; last_err_locked = locked; end
        if (locked && !locked_q) lock_edge = edge_cnt;
        locked_q = locked;
    end

    task automatic check(input string tag, input int obs, input int exp);
        nvec++;
        if (obs != exp) begin
            nmis++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Strobe pattern m high for 2 clocks, then low for 2 clocks.
    task automatic pulse(input logic [3:0] m);
        faz = m;
        tick(2);
        faz = 4'b0000;
        tick(2);
    endtask

    task automatic seq(input int n);
        for (int k = 0; k < n; k++) begin
            pulse(4'b0001); pulse(4'b0010); pulse(4'b0100); pulse(4'b1000);
        end
    endtask

    int ref_e, pv0, e0, p0;

    initial begin
        // Reset held while the strobes toggle.
        faz = 4'b1111; tick(2);
        faz = 4'b0101; tick(2);
        check("rst_locked", int'(locked), 0);
        check("rst_phase", int'(phase), 0);
        check("rst_phase_valid", int'(phase_valid), 0);
        check("rst_p800", int'(p800_stb), 0);
        check("rst_err_stb", int'(err_stb), 0);
        check("rst_err_code", int'(err_code), 0);
        check("rst_no_events", pv_cnt + err_cnt + p800_cnt, 0);
        faz = 4'b0000; tick(3);
        rst_n = 1'b1; tick(3);

        // Pin-to-phase_valid latency: SYNC_STAGES+1 = 3 edges.
        ref_e = edge_cnt;
        pulse(4'b0001);
        check("latency", last_pv_edge - ref_e, 3);
        check("first_phase", last_phase, 0);
        check("first_pv_count", pv_cnt, 1);

        // Lock after the 4th clean FAZ4.
        pulse(4'b0010); pulse(4'b0100); pulse(4'b1000);
        seq(2);
        pulse(4'b0001); pulse(4'b0010); pulse(4'b0100);
        check("not_locked_yet", int'(locked), 0);
        pulse(4'b1000);
        check("locked", int'(locked), 1);
        check("lock_with_faz4", lock_edge - last_pv_edge, 0);
        check("lock_phase", last_phase, 3);
        check("lock_no_err", err_cnt, 0);

        // p800 on the 16th FAZ1 only.
        p0 = p800_cnt;
        seq(15);
        check("p800_none_15", p800_cnt - p0, 0);
        pulse(4'b0001);
        check("p800_on_16", p800_cnt - p0, 1);
        check("p800_with_faz1", last_p800_edge - last_pv_edge, 0);
        pulse(4'b0010); pulse(4'b0100); pulse(4'b1000);

        // Order fault: FAZ1, FAZ2, FAZ4.
        e0 = err_cnt; pv0 = pv_cnt;
        pulse(4'b0001); pulse(4'b0010); pulse(4'b1000);
        check("order_err_stb", err_cnt - e0, 1);
        check("order_err_code", int'(err_code), 1);
        check("order_unlock_at_stb", int'(last_err_locked), 0);
        check("order_locked", int'(locked), 0);
        check("order_pv_count", pv_cnt - pv0, 2);

        // Relock; divider must restart from zero.
        seq(3);
        pulse(4'b0001); pulse(4'b0010); pulse(4'b0100);
        check("relock_not_yet", int'(locked), 0);
        pulse(4'b1000);
        check("relock", int'(locked), 1);
        p0 = p800_cnt;
        seq(15);
        check("relock_p800_none_15", p800_cnt - p0, 0);
        pulse(4'b0001);
        check("relock_p800_on_16", p800_cnt - p0, 1);
        pulse(4'b0010); pulse(4'b0100); pulse(4'b1000);

        // Overlap while locked.
        e0 = err_cnt;
        pulse(4'b0001); pulse(4'b0110);
        check("multi_err_stb", err_cnt - e0, 1);
        check("multi_err_code", int'(err_code), 2);
        check("multi_locked", int'(locked), 0);

        // Overlap in HUNT: silent, next single edge is accepted.
        e0 = err_cnt; pv0 = pv_cnt;
        pulse(4'b0110);
        check("hunt_multi_no_err", err_cnt - e0, 0);
        check("hunt_multi_no_pv", pv_cnt - pv0, 0);
        check("hunt_multi_code_held", int'(err_code), 2);
        pulse(4'b0001);
        check("hunt_accept", pv_cnt - pv0, 1);
        pulse(4'b0010); pulse(4'b0100); pulse(4'b1000);
        seq(3);
        check("lock_after_hunt", int'(locked), 1);

        // Dropout MAX_GAP cycles after the last accepted edge.
        e0 = err_cnt; ref_e = last_pv_edge;
        tick(80);
        check("gap_err_stb", err_cnt - e0, 1);
        check("gap_delay", last_err_edge - ref_e, 64);
        check("gap_err_code", int'(err_code), 3);
        check("gap_locked", int'(locked), 0);

        // Edge landing in the expiry cycle wins.
        seq(4);
        check("lock_before_race", int'(locked), 1);
        e0 = err_cnt; ref_e = last_pv_edge;
        while (edge_cnt < ref_e + 61) tick(1);
        pulse(4'b0001);
        check("race_pv_delay", last_pv_edge - ref_e, 64);
        check("race_no_err", err_cnt - e0, 0);
        check("race_locked", int'(locked), 1);
        ref_e = last_pv_edge;
        tick(70);
        check("race_gap_restart", last_err_edge - ref_e, 64);
        check("race_gap_code", int'(err_code), 3);

`ifdef FAZ_ERR_COUNT_EN
        // Counter clear, saturation, and clear coinciding with a fault.
        err_clr = 1'b1; tick(1); err_clr = 1'b0; tick(1);
        check("cnt_clear", int'(err_count), 0);
        for (int k = 0; k < 300; k++) begin
            seq(4);
            pulse(4'b0001); pulse(4'b0100);
        end
        check("cnt_saturate", int'(err_count), 255);
        seq(4);
        pulse(4'b0001);
        e0 = err_cnt; ref_e = edge_cnt;
        faz = 4'b0100; tick(2);
        faz = 4'b0000; tick(1);
        err_clr = 1'b1; tick(1);
        err_clr = 1'b0; tick(2);
        check("cnt_clr_err_timing", last_err_edge - ref_e, 3);
        check("cnt_clr_with_err", int'(err_count), 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
